// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, state encoding,
// datapath-select encodings and the control-word struct.
package mc_control_fsm_pkg;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_BR_NT = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    I_ARITH,
    I_ARITH_IMM,
    I_LOAD,
    I_STORE,
    I_BRANCH,
    I_JAL,
    I_JALR,
    I_ECALL,
    I_UNKNOWN
  } instr_e;

  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;

  localparam logic       IORD_PC       = 1'b0;
  localparam logic       IORD_ALUOUT   = 1'b1;

  localparam logic [1:0] M2R_ALUOUT    = 2'd0;
  localparam logic [1:0] M2R_MDR       = 2'd1;
  localparam logic [1:0] M2R_ALU       = 2'd2;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_REG     = 1'b1;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;

  localparam logic [1:0] ALU_ADD       = 2'd0;
  localparam logic [1:0] ALU_BRANCH    = 2'd1;
  localparam logic [1:0] ALU_FUNCT     = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic instr_e decode_opcode(input logic [6:0] op);
    instr_e r;
    case (op)
      OP_ARITH:     r = I_ARITH;
      OP_ARITH_IMM: r = I_ARITH_IMM;
      OP_LOAD:      r = I_LOAD;
      OP_STORE:     r = I_STORE;
      OP_BRANCH:    r = I_BRANCH;
      OP_JAL:       r = I_JAL;
      OP_JALR:      r = I_JALR;
      OP_ECALL:     r = I_ECALL;
      default:      r = I_UNKNOWN;
    endcase
    return r;
  endfunction

  // Sequential fall-through: ALU computes PC+4 and the result is written to PC.
  function automatic ctrl_t ctrl_pc_plus_four();
    ctrl_t c;
    c           = CTRL_IDLE;
    c.pc_write  = 1'b1;
    c.pc_source = PC_SRC_ALU;
    c.alu_src_a = SRC_A_PC;
    c.alu_src_b = SRC_B_FOUR;
    c.alu_op    = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_perf_counter.sv
// perf_counter: free-running wrap-around event counter with synchronous clear.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM with cycle/retired performance counters.
// Define MEM_HANDSHAKE_EN to make IF/MEM wait for mem_ready; otherwise they take one cycle.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  state_e state;
  instr_e instr;
  ctrl_t  ctrl;
  logic   mem_done;
  logic   ctr_clear;
  logic   cycle_en;

  assign instr = decode_opcode(opcode);

`ifdef MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  // Unknown opcodes take the ECALL path with halt_req forced low.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF: begin
          if (mem_done) state <= S_ID;
        end
        S_ID: begin
          if (instr == I_ECALL) begin
            state <= halt_req ? S_HALT : S_IF;
          end else if (instr == I_UNKNOWN) begin
            state <= S_IF;
          end else begin
            state <= S_EX;
          end
        end
        S_EX: begin
          case (instr)
            I_ARITH, I_ARITH_IMM, I_JALR: state <= S_WB;
            I_LOAD, I_STORE:              state <= S_MEM;
            I_BRANCH:                     state <= alu_bcond ? S_IF : S_BR_NT;
            default:                      state <= S_IF;
          endcase
        end
        S_MEM: begin
          if (mem_done) state <= (instr == I_LOAD) ? S_WB : S_IF;
        end
        S_WB, S_BR_NT: state <= S_IF;
        S_HALT:        state <= S_HALT;
        default:       state <= S_IF;
      endcase
    end
  end

  always_comb begin
    // NOTE: full default before the case keeps every path assigned, so no latches are inferred.
    ctrl = CTRL_IDLE;
    case (state)
      S_IF: begin
        ctrl.i_or_d   = IORD_PC;
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_done;
      end
      S_ID: begin
        if (instr == I_ECALL || instr == I_UNKNOWN) begin
          if (!(instr == I_ECALL && halt_req)) ctrl = ctrl_pc_plus_four();
        end else begin
          // Branch/jump target PC+imm is parked in ALUOut for later states.
          ctrl.alu_src_a = SRC_A_PC;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
      end
      S_EX: begin
        case (instr)
          I_ARITH: begin
            ctrl.alu_src_a = SRC_A_REG;
            ctrl.alu_src_b = SRC_B_REG;
            ctrl.alu_op    = ALU_FUNCT;
          end
          I_ARITH_IMM: begin
            ctrl.alu_src_a = SRC_A_REG;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_FUNCT;
          end
          I_LOAD, I_STORE, I_JALR: begin
            ctrl.alu_src_a = SRC_A_REG;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          I_BRANCH: begin
            ctrl.alu_src_a = SRC_A_REG;
            ctrl.alu_src_b = SRC_B_REG;
            ctrl.alu_op    = ALU_BRANCH;
            ctrl.pc_write  = alu_bcond;
            ctrl.pc_source = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_ALU;
          end
          I_JAL: begin
            // rd <= PC+4 from the ALU while PC <= PC+imm from ALUOut, same cycle.
            ctrl            = ctrl_pc_plus_four();
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = M2R_ALU;
            ctrl.pc_source  = PC_SRC_ALUOUT;
          end
          default: ctrl = CTRL_IDLE;
        endcase
      end
      S_MEM: begin
        if (instr == I_STORE && mem_done) ctrl = ctrl_pc_plus_four();
        ctrl.i_or_d    = IORD_ALUOUT;
        ctrl.mem_read  = (instr == I_LOAD);
        ctrl.mem_write = (instr == I_STORE);
      end
      S_WB: begin
        ctrl           = ctrl_pc_plus_four();
        ctrl.reg_write = 1'b1;
        case (instr)
          I_LOAD: ctrl.mem_to_reg = M2R_MDR;
          I_JALR: begin
            ctrl.mem_to_reg = M2R_ALU;
            ctrl.pc_source  = PC_SRC_ALUOUT;
          end
          default: ctrl.mem_to_reg = M2R_ALUOUT;
        endcase
      end
      S_BR_NT: ctrl = ctrl_pc_plus_four();
      S_HALT:  ctrl.is_halted = 1'b1;
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign pc_write   = ctrl.pc_write;
  assign pc_source  = ctrl.pc_source;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign is_halted  = ctrl.is_halted;

  assign ctr_clear = ~reset;
  assign cycle_en  = (state != S_HALT);

  perf_counter #(.CNT_W(CNT_W)) u_cycle_ctr (
    .clk    (clk),
    .clear  (ctr_clear),
    .enable (cycle_en),
    .count  (cycle_count)
  );

  perf_counter #(.CNT_W(CNT_W)) u_retired_ctr (
    .clk    (clk),
    .clear  (ctr_clear),
    .enable (ctrl.pc_write),
    .count  (retired_count)
  );

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of both performance counters.
REQ-002 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-low reset; opcode in 7 IR[6:0]; alu_bcond in 1 branch-compare result; halt_req in 1 ECALL halt condition (x17==10); mem_ready in 1 memory done.
REQ-003 SHALL have outputs: pc_write 1; pc_source 1 (0=ALU result, 1=ALUOut); i_or_d 1 (0=PC, 1=ALUOut); mem_read 1; mem_write 1; ir_write 1; mem_to_reg 2 (0=ALUOut, 1=MDR, 2=ALU result); reg_write 1; alu_src_a 1 (0=PC, 1=A); alu_src_b 2 (0=B, 1=const 4, 2=imm); alu_op 2 (0=add, 1=branch compare, 2=funct-decoded); is_halted 1; cycle_count CNT_W; retired_count CNT_W.

Function
REQ-004 SHALL be a Moore FSM with states IF, ID, EX, MEM, WB, BR_NT, HALT; all outputs SHALL be decoded from state and opcode only; unlisted outputs SHALL be 0.
REQ-005 IF: i_or_d=0, mem_read=1; on completion ir_write=1, go to ID.
REQ-006 ID, ECALL: halt_req=1 goes to HALT; otherwise ALU PC+4, pc_write=1, pc_source=0, go to IF.
REQ-007 ID, all other opcodes: ALU PC+imm (alu_op=0) latched into ALUOut; unknown opcode SHALL behave as ECALL with halt_req=0.
REQ-008 EX, ARITHMETIC/ARITHMETIC_IMM: alu_src_a=1, alu_src_b=0/2, alu_op=2, go to WB.
REQ-009 EX, LOAD/STORE: A+imm, alu_op=0, go to MEM.
REQ-010 EX, BRANCH: A vs B, alu_op=1; alu_bcond=1 sets pc_write=1, pc_source=1, goes to IF; alu_bcond=0 goes to BR_NT.
REQ-011 BR_NT: ALU PC+4, pc_write=1, pc_source=0, go to IF.
REQ-012 EX, JAL: ALU PC+4, reg_write=1, mem_to_reg=2, pc_write=1, pc_source=1 (PC+imm), go to IF.
REQ-013 EX, JALR: A+imm into ALUOut, go to WB.
REQ-014 MEM: i_or_d=1; LOAD sets mem_read=1 and goes to WB on completion; STORE sets mem_write=1 and, on completion, pc_write=1 with ALU PC+4, pc_source=0, goes to IF.
REQ-015 WB: ALU PC+4, pc_write=1, pc_source=0, reg_write=1, then IF; mem_to_reg SHALL be 1 for LOAD, 0 for arithmetic, and for JALR 2 with pc_source=1.
REQ-016 HALT: absorbing state; is_halted=1; all strobes 0.
REQ-017 cycle_count SHALL increment every cycle not in HALT; retired_count SHALL increment each cycle pc_write=1; both SHALL wrap modulo 2^CNT_W.

Reset
REQ-018 reset=0 at a rising clk edge SHALL force IF, zero both counters, clear is_halted, from any state, including mid-MEM wait.
REQ-019 The cycle with reset=0 SHALL NOT count toward cycle_count.

Configuration
REQ-020 With MEM_HANDSHAKE_EN defined, IF/MEM completion SHALL be the first cycle mem_ready=1; strobes SHALL hold steady until then.
REQ-021 Without MEM_HANDSHAKE_EN, mem_ready SHALL be ignored; IF/MEM complete in one cycle.

Structure
REQ-022 Opcode macros SHALL come from opcodes.v; state encoding plus pc_source/mem_to_reg/alu_src_b/alu_op encodings SHALL live in shared header control_defs.v.
REQ-023 Counters SHALL be one sub-module perf_counter (enable, synchronous clear, CNT_W param), instantiated twice.

Verification
REQ-024 ADD, handshake off: IF,ID,EX,WB; one pc_write; cycle_count=4, retired_count=1.
REQ-025 LW, handshake on, mem_ready high on 4th IF cycle and 3rd MEM cycle: 10 cycles, reg_write with mem_to_reg=1 only in WB.
REQ-026 BEQ with alu_bcond=1: 3 cycles, pc_source=1; with alu_bcond=0: 4 cycles via BR_NT, pc_source=0.
REQ-027 JAL: 3 cycles; reg_write, pc_write, mem_to_reg=2 all in same EX cycle.
REQ-028 ECALL with halt_req=1: HALT after ID; is_halted=1; counters frozen for 20 further cycles.
REQ-029 reset=0 during 2nd MEM wait cycle of SW: next state IF, mem_write=0, counters 0.
